wb_stage: RTL and testbench

Writeback stage of the rv32 pipeline. Consumes the instruction and `wb_sel` produced by the writeback-control register, together with the ALU result, PC+4 and the data-memory read response. It selects and formats the writeback value, including load byte/halfword extraction and sign/zero extension. It drives the register-file write port through registered outputs, and back-pressures upstream with `in_ready` while a load waits for memory.

---
 rtl/rv32_pkg.sv | 38 +++
 rtl/load_align.sv | 45 ++++
 rtl/wb_stage.sv | 131 +++++++++++++
 tb/tb_wb_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline definitions: opcodes, writeback select encodings,
// load funct3 codes and the writeback-stage state enum.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_RSV = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_e;

    // True for opcodes whose result is written to rd.
    function automatic logic is_writing(input logic [6:0] opc);
        return (opc == OPC_LUI)  || (opc == OPC_AUIPC)  || (opc == OPC_JAL) ||
               (opc == OPC_JALR) || (opc == OPC_LOAD)   || (opc == OPC_OP_IMM) ||
               (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects byte/half/word from an aligned read word
// and sign- or zero-extends it; flags misaligned or illegal load widths.
//   mem_rdata  : aligned 32-bit read word
//   funct3     : load funct3
//   addr       : byte address bits [1:0]
//   data_c     : extended load value
//   misalign_c : access misaligned or funct3 not a load width
module load_align
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    output logic [XLEN-1:0] data_c,
    output logic            misalign_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = mem_rdata[{addr, 3'b000} +: 8];
        half_v     = mem_rdata[{addr[1], 4'b0000} +: 16];
        data_c     = '0;
        misalign_c = 1'b0;
        case (funct3)
            F3_LB:  data_c = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data_c = {24'h000000, byte_v};
            F3_LH: begin
                data_c     = {{16{half_v[15]}}, half_v};
                misalign_c = addr[0];
            end
            F3_LHU: begin
                data_c     = {16'h0000, half_v};
                misalign_c = addr[0];
            end
            F3_LW: begin
                data_c     = mem_rdata;
                misalign_c = (addr != 2'b00);
            end
            default: misalign_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rv32 writeback stage: selects ALU / PC+4 / load data, waits for the
// memory response on loads, and drives a registered register-file port.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake (ready low while a load waits)
//   instruction     : opcode / rd / funct3 source
//   wb_sel          : writeback source select for non-loads
//   alu_result      : ALU value, also the load byte address
//   pc_plus4        : link value
//   mem_rdata/rvalid: load response
//   rf_we/waddr/wdata: registered register-file write port
//   err_misalign    : one-cycle pulse on a misaligned load
//   err_timeout     : sticky flag when a load response never arrives
module wb_stage
    import rv32_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [1:0]      wb_sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            err_misalign,
    output logic            err_timeout
);

    localparam int unsigned CNT_W = 16;

    wb_state_e         state;
    logic [4:0]        ld_rd;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_addr;
    logic [CNT_W-1:0]  wait_cnt;

    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [2:0]        align_funct3;
    logic [1:0]        align_addr;
    logic [XLEN-1:0]   ld_data;
    logic              ld_misalign;
    logic              unused_bits;

    assign opcode      = instruction[6:0];
    assign rd          = instruction[11:7];
    assign funct3      = instruction[14:12];
    assign unused_bits = ^instruction[31:15];
    assign in_ready    = (state == S_IDLE);

    // The aligner checks the incoming load in IDLE and extracts the
    // response using the latched access in WAIT_MEM.
    always_comb begin
        align_funct3 = (state == S_IDLE) ? funct3 : ld_funct3;
        align_addr   = (state == S_IDLE) ? alu_result[1:0] : ld_addr;
    end

    load_align u_load_align (
        .mem_rdata  (mem_rdata),
        .funct3     (align_funct3),
        .addr       (align_addr),
        .data_c     (ld_data),
        .misalign_c (ld_misalign)
    );

    // Stage FSM with registered write port and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            wait_cnt     <= '0;
            ld_rd        <= '0;
            ld_funct3    <= '0;
            ld_addr      <= '0;
        end else begin
            rf_we        <= 1'b0;
            err_misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (opcode == OPC_LOAD) begin
                            if (ld_misalign) begin
                                err_misalign <= 1'b1;
                            end else begin
                                ld_rd     <= rd;
                                ld_funct3 <= funct3;
                                ld_addr   <= alu_result[1:0];
                                wait_cnt  <= '0;
                                state     <= S_WAIT_MEM;
                            end
                        end else begin
                            rf_we    <= is_writing(opcode) && (rd != 5'd0) && (wb_sel != WB_RSV);
                            rf_waddr <= rd;
                            // WB_MEM / WB_RSV on a non-load keep the old data.
                            if (wb_sel == WB_ALU) begin
                                rf_wdata <= alu_result;
                            end else if (wb_sel == WB_PC4) begin
                                rf_wdata <= pc_plus4;
                            end
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        rf_we    <= (ld_rd != 5'd0);
                        rf_waddr <= ld_rd;
                        rf_wdata <= ld_data;
                        state    <= S_IDLE;
                    end else if (wait_cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected writes,
// a negedge monitor pops and compares each write / misalign event.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic [1:0]  wb_sel = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] pc_plus4 = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err_misalign;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    wb_stage #(.LOAD_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .wb_sel       (wb_sel),
        .alu_result   (alu_result),
        .pc_plus4     (pc_plus4),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [2:0] f3);
        return {17'h0, f3, rd, opc};
    endfunction

    // Monitor: every write or misalign pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst && (rf_we || err_misalign)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: we=%0b waddr=%0d wdata=0x%08h mis=%0b, none expected",
                         rf_we, rf_waddr, rf_wdata, err_misalign);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.mis) begin
                    check("mis_we", 32'(rf_we), 32'd0);
                    check("mis_pulse", 32'(err_misalign), 32'd1);
                end else begin
                    check("wr_we", 32'(rf_we), 32'd1);
                    check("wr_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
                    check("wr_wdata", rf_wdata, mon_e.wdata);
                    check("wr_nomis", 32'(err_misalign), 32'd0);
                end
            end
        end
    end

    // Present one transaction for one accepting edge; returns at edge + 1.
    task automatic issue(input logic [31:0] instr, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        instruction = instr;
        wb_sel      = sel;
        alu_result  = alu;
        pc_plus4    = pc4;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
    endtask

    task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic mis);
        exp_t e;
        e.we = we; e.waddr = a; e.wdata = d; e.mis = mis;
        sb.push_back(e);
    endtask

    // Called right after load acceptance; response sampled k edges later.
    task automatic respond(input int k, input logic [31:0] data);
        for (int i = 0; i < k - 1; i++) begin
            check("ld_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("ld_busy", 32'(in_ready), 32'd0);
        mem_rdata  = data;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check("ld_done_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_mis", 32'(err_misalign), 32'd0);
        check("rst_tmo", 32'(err_timeout), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // ALU and link writes, back to back.
        push(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        issue(32'h0050_0293, 2'b01, 32'h0000_1234, 32'h0);
        push(1'b1, 5'd1, 32'h0000_0104, 1'b0);
        issue(mk(7'b1101111, 5'd1, 3'b000), 2'b10, 32'h0, 32'h0000_0104);
        // rd = 0: no write, data still updated.
        issue(mk(7'b1101111, 5'd0, 3'b000), 2'b10, 32'h0, 32'h0000_0200);
        check("jal_x0_we", 32'(rf_we), 32'd0);
        // Reserved select: no write, data held.
        issue(mk(7'b0110011, 5'd7, 3'b000), 2'b11, 32'hDEAD_BEEF, 32'h0);
        check("rsv_we", 32'(rf_we), 32'd0);
        check("rsv_hold", rf_wdata, 32'h0000_0200);
        // Store opcode never writes.
        issue(mk(7'b0100011, 5'd8, 3'b010), 2'b01, 32'h1111_1111, 32'h0);
        check("store_we", 32'(rf_we), 32'd0);
        push(1'b1, 5'd9, 32'hABCD_0000, 1'b0);
        issue(mk(7'b0110111, 5'd9, 3'b000), 2'b01, 32'hABCD_0000, 32'h0);

        // Loads.
        push(1'b1, 5'd10, 32'hFFFF_FF80, 1'b0);
        issue(mk(7'b0000011, 5'd10, 3'b000), 2'b00, 32'h0000_1003, 32'h0);
        respond(3, 32'h80FF_0000);
        push(1'b1, 5'd10, 32'h0000_0080, 1'b0);
        issue(mk(7'b0000011, 5'd10, 3'b100), 2'b01, 32'h0000_1003, 32'h0);
        respond(1, 32'h80FF_0000);
        push(1'b1, 5'd11, 32'hFFFF_80FF, 1'b0);
        issue(mk(7'b0000011, 5'd11, 3'b001), 2'b00, 32'h0000_2002, 32'h0);
        check("lh_nomis", 32'(err_misalign), 32'd0);
        respond(2, 32'h80FF_0000);
        push(1'b1, 5'd12, 32'h0000_ABCD, 1'b0);
        issue(mk(7'b0000011, 5'd12, 3'b101), 2'b00, 32'h0000_2000, 32'h0);
        respond(1, 32'h1234_ABCD);
        push(1'b1, 5'd13, 32'hCAFE_BABE, 1'b0);
        issue(mk(7'b0000011, 5'd13, 3'b010), 2'b00, 32'h0000_3000, 32'h0);
        respond(2, 32'hCAFE_BABE);

        // Misaligned and illegal-width loads.
        push(1'b0, 5'd0, 32'h0, 1'b1);
        issue(mk(7'b0000011, 5'd14, 3'b010), 2'b00, 32'h0000_0001, 32'h0);
        check("lw_mis_ready", 32'(in_ready), 32'd1);
        push(1'b0, 5'd0, 32'h0, 1'b1);
        issue(mk(7'b0000011, 5'd14, 3'b001), 2'b00, 32'h0000_0003, 32'h0);
        push(1'b0, 5'd0, 32'h0, 1'b1);
        issue(mk(7'b0000011, 5'd14, 3'b011), 2'b00, 32'h0000_0000, 32'h0);
        @(posedge clk);
        #1;
        check("mis_one_cycle", 32'(err_misalign), 32'd0);

        // Stray response in IDLE is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check("stray_we", 32'(rf_we), 32'd0);

        // Timeout after four WAIT_MEM cycles.
        issue(mk(7'b0000011, 5'd15, 3'b010), 2'b00, 32'h0000_4000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("tmo_early", 32'(err_timeout), 32'd0);
            check("tmo_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("tmo_early", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        check("tmo_set", 32'(err_timeout), 32'd1);
        check("tmo_ready", 32'(in_ready), 32'd1);
        check("tmo_no_we", 32'(rf_we), 32'd0);
        push(1'b1, 5'd6, 32'h0000_0055, 1'b0);
        issue(mk(7'b0010011, 5'd6, 3'b000), 2'b01, 32'h0000_0055, 32'h0);
        @(posedge clk);
        #1;
        check("tmo_sticky", 32'(err_timeout), 32'd1);

        // Reset during WAIT_MEM, then a stray response.
        issue(mk(7'b0000011, 5'd13, 3'b010), 2'b00, 32'h0000_5000, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mem_rdata  = 32'hFFFF_FFFF;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check("rstw_we", 32'(rf_we), 32'd0);
        check("rstw_waddr", 32'(rf_waddr), 32'd0);
        check("rstw_wdata", rf_wdata, 32'd0);
        check("rstw_tmo", 32'(err_timeout), 32'd0);
        check("rstw_mis", 32'(err_misalign), 32'd0);
        check("rstw_ready", 32'(in_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
